// File: rtl/mult_pkg.sv
// Shared constants and the product model for the 5x5 unsigned multiply
// lookup table.
//   N      : operand width in bits
//   ADDR_W : address width, {a, b}
//   DATA_W : product width, wide enough for (2^N-1)^2 without truncation
//   DEPTH  : number of table words
//   product(a, b) : 2N-bit unsigned product. It fills the table.
package mult_pkg;

  localparam int N      = 5;
  localparam int ADDR_W = 2 * N;
  localparam int DATA_W = 2 * N;
  localparam int DEPTH  = 1 << ADDR_W;

  function automatic logic [DATA_W-1:0] product(input logic [N-1:0] a,
                                                input logic [N-1:0] b);
    return DATA_W'(a) * DATA_W'(b);
  endfunction

endpackage

// File: rtl/rom_if.sv
// Read bus of the product lookup ROM.
//   endereco : read address {a, b}, driven by the master
//   leitura  : registered read data a*b, driven by the ROM (slave)
interface rom_if;
  import mult_pkg::*;

  logic [ADDR_W-1:0] endereco;
  logic [DATA_W-1:0] leitura;

  modport master (output endereco, input leitura);
  modport slave  (input endereco, output leitura);

endinterface

// File: rtl/rom.sv
// Synchronous lookup ROM holding every product of two unsigned N-bit operands.
// The word at address {a, b} is a*b. Read data is registered, so the latency
// is one cycle, and a new address is accepted on every cycle.
//   clock : system clock, rising edge
//   reset : asynchronous, active-high; forces leitura to 0
//   bus   : rom_if.slave (endereco in, leitura out)
module rom
  import mult_pkg::*;
(
  input  logic  clock,
  input  logic  reset,
  rom_if.slave  bus
);

  logic [DATA_W-1:0] table_mem [DEPTH];

  // The contents are constant wiring that is fixed at elaboration. They are
  // not affected by reset, and every entry is defined.
  for (genvar ga = 0; ga < (1 << N); ga++) begin : g_a
    for (genvar gb = 0; gb < (1 << N); gb++) begin : g_b
      assign table_mem[(ga << N) | gb] = product(N'(ga), N'(gb));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.leitura <= '0;
    end else begin
      bus.leitura <= table_mem[bus.endereco];
    end
  end

endmodule

// File: tb/tb_rom.sv
module tb_rom;
  import mult_pkg::*;

  logic clock;
  logic reset;
  int   total;
  int   bad;

  rom_if bus ();

  rom dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [DATA_W-1:0] got,
                     input logic [DATA_W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic rd(input string tag, input int a, input int b,
                    input logic [DATA_W-1:0] exp);
    @(negedge clock);
    bus.endereco = {5'(a), 5'(b)};
    @(posedge clock);
    #1;
    chk(tag, bus.leitura, exp);
  endtask

  initial begin
    logic [DATA_W-1:0] held;
    int a_i, b_i;
    total = 0;
    bad   = 0;

    // Power-up reset holds the output at 0 before any clock edge.
    reset        = 1'b1;
    bus.endereco = 10'h2A3;
    #1;
    chk("reset_powerup", bus.leitura, 10'd0);

    @(negedge clock);
    reset = 1'b0;
    rd("first_after_release", 5, 10, 10'd50);

    rd("dir_5x0",   5,  0,  10'd0);
    rd("dir_31x31", 31, 31, 10'd961);
    rd("dir_3x8",   3,  8,  10'd24);
    rd("dir_17x15", 17, 15, 10'd255);
    rd("bnd_0x0",   0,  0,  10'd0);
    rd("bnd_1x31",  1,  31, 10'd31);
    rd("bnd_31x1",  31, 1,  10'd31);
    rd("bnd_16x16", 16, 16, 10'd256);
    rd("bnd_0x19",  0,  19, 10'd0);
    rd("bnd_7x7",   7,  7,  10'd49);

    // Check that nothing propagates between edges. The address moves twice
    // before the edge, and only the last value is sampled at the edge.
    @(negedge clock);
    held = bus.leitura;
    bus.endereco = {5'd2, 5'd3};
    #1 bus.endereco = {5'd9, 5'd9};
    #1 bus.endereco = {5'd12, 5'd11};
    #1 chk("glitch_hold", bus.leitura, held);
    @(posedge clock);
    #1 chk("glitch_sampled", bus.leitura, 10'd132);
    bus.endereco = {5'd31, 5'd31};
    #1 chk("glitch_post_edge", bus.leitura, 10'd132);

    // Sweep every address back-to-back, with an asynchronous reset in the middle.
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clock);
      bus.endereco = 10'(i);
      @(posedge clock);
      #1;
      a_i = i >> 5;
      b_i = i & 31;
      chk("sweep", bus.leitura, 10'(a_i * b_i));
      if (i == 600) begin
        #1 reset = 1'b1;
        #1 chk("reset_mid", bus.leitura, 10'd0);
        #1 reset = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rom.md
Name: rom

Overview:
- Synchronous lookup ROM holding every product of two unsigned 5-bit operands.
- The address is the concatenation {a, b}. The read data is a*b.
- Sits in the multiplier datapath as the table-based reference and implementation of a 5x5 unsigned multiply.
- Contents are fixed at elaboration. The block has no write port.

Parameters:
- N, 5, operand width in bits. Address width and data width are both 2*N.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- endereco  input  2N (10)  read address; bits [2N-1:N] = operand a, bits [N-1:0] = operand b, both unsigned.
- leitura  output  2N (10)  registered read data = a*b.

Behaviour:
- Interface: one clock (clock); reset is asynchronous and active-high (reset).
- Storage:
  - 2^(2N) = 1024 words of 2N bits.
  - Word at address {a,b} holds the unsigned product a*b.
  - The maximum product is 31*31 = 961, so it fits in 10 bits with no truncation.
- Initialisation:
  - Table is generated at elaboration by nested loops over a and b.
  - No external memory file. No runtime write path.
  - Contents are independent of reset.
- Read:
  - leitura is registered. On each rising clock edge with reset low, leitura <= table[endereco].
  - Latency is exactly 1 cycle from address to data.
  - A new address may be applied every cycle (full throughput).
- Reset:
  - While reset is high, leitura = 0, asynchronously. This applies whether reset is asserted mid-operation or at power-up.
  - The first read after release returns data on the first rising edge with reset low.
- Address changes between clock edges have no effect on leitura until the next rising edge. There is no combinational path from endereco to leitura.
- Boundary addresses:
  - 0x000 -> 0.
  - {a,0} and {0,b} -> 0.
  - 0x3FF -> 961.
- All addresses are valid. No out-of-range condition exists.
- No X propagation: every one of the 1024 entries must be defined.

Decomposition:
- Shared package mult_pkg:
  - constant N = 5.
  - derived ADDR_W = DATA_W = 2*N.
  - function product(a,b) returning the 2N-bit unsigned product, used for table init and by the bench as scoreboard model.
- No sub-module needed. Table array, init loop and output register live in rom.

Test Plan:
- Reset check: assert reset with any address, no clock edge -> leitura = 0 immediately; release -> next edge returns table value.
- Directed products, one per cycle with 1-cycle latency checked:
  - a=5, b=10 -> 50.
  - a=5, b=0 -> 0.
  - a=31, b=31 -> 961.
  - a=3, b=8 -> 24.
  - a=17, b=15 -> 255.
- Boundaries:
  - address 0x000 -> 0.
  - {1,31} -> 31.
  - {31,1} -> 31.
  - {16,16} -> 256.
- Exhaustive sweep: all 1024 addresses back-to-back, one per cycle -> each leitura equals product(a,b) from the previous cycle's address.
- Mid-stream reset: during the sweep, assert reset asynchronously between edges -> leitura goes to 0 at once. Deassert -> the sweep resumes with correct data after 1 cycle.
- Glitch immunity: change endereco twice between edges -> leitura reflects only the value sampled at the rising edge.
